// File: rtl/seq_detect_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern detector.
// The functions build the KMP transition tables from the pattern parameter.
package seq_detect_pkg;

    localparam int MAX_PAT_LEN = 8;

    typedef enum logic [3:0] {S0, S1, S2, S3, S4, S5, S6, S7, S8} state_e;

    // Pattern bit p counts from the first bit received, which is the MSB.
    function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pattern,
                                     input int len, input int p);
        logic [MAX_PAT_LEN-1:0] shifted;
        shifted = pattern >> (len - 1 - p);
        return shifted[0];
    endfunction

    // Longest proper prefix of the whole pattern that is also a suffix.
    function automatic int failure(input logic [MAX_PAT_LEN-1:0] pattern, input int len);
        int   best;
        logic ok;
        best = 0;
        for (int j = 1; j < len; j++) begin
            ok = 1'b1;
            for (int q = 0; q < j; q++)
                if (pat_bit(pattern, len, q) != pat_bit(pattern, len, len - j + q))
                    ok = 1'b0;
            if (ok)
                best = j;
        end
        return best;
    endfunction

    // Longest j such that (first k pattern bits, then in_bit) ends with the first j pattern bits.
    function automatic int next_state(input logic [MAX_PAT_LEN-1:0] pattern, input int len,
                                      input int k, input logic in_bit);
        int   best;
        int   idx;
        logic ok;
        logic sbit;
        best = 0;
        for (int j = 1; j <= len; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int q = 0; q < j; q++) begin
                    idx  = k + 1 - j + q;
                    sbit = (idx == k) ? in_bit : pat_bit(pattern, len, idx);
                    if (sbit != pat_bit(pattern, len, q))
                        ok = 1'b0;
                end
                if (ok)
                    best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detect_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/seq_detect.sv
// Moore serial pattern detector with KMP transitions built at elaboration
// and a saturating match counter.
module seq_detect
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i,
    input  logic                             i_valid,
    input  logic                             clear,
    output logic                             o,
    output logic [CNT_W-1:0]                 match_count,
    output logic [$clog2(PAT_LEN+1)-1:0]     state_o
);

    localparam int                     SW      = $clog2(PAT_LEN + 1);
    localparam logic [MAX_PAT_LEN-1:0] PAT8    = MAX_PAT_LEN'(PATTERN);
    localparam state_e                 S_MATCH = state_e'(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
        $error("seq_detect: PAT_LEN must be in 2..8");
    end

    logic [3:0] w_tbl0 [MAX_PAT_LEN+1];
    logic [3:0] w_tbl1 [MAX_PAT_LEN+1];

    // MATCH transitions as if from the failure state (overlap) or from S0 (restart).
    for (genvar k = 0; k <= MAX_PAT_LEN; k++) begin : g_tbl
        if (k <= PAT_LEN) begin : g_used
            localparam int SRC = (k == PAT_LEN) ?
                                 ((OVERLAP != 0) ? failure(PAT8, PAT_LEN) : 0) : k;
            assign w_tbl0[k] = 4'(next_state(PAT8, PAT_LEN, SRC, 1'b0));
            assign w_tbl1[k] = 4'(next_state(PAT8, PAT_LEN, SRC, 1'b1));
        end else begin : g_unused
            assign w_tbl0[k] = '0;
            assign w_tbl1[k] = '0;
        end
    end

    state_e r_state;
    state_e w_next;
    logic   w_enter_match;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S0;
        else
            r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next        = r_state;
        w_enter_match = 1'b0;
        if (clear) begin
            w_next = S0;
        end else if (i_valid) begin
            w_next        = state_e'(i ? w_tbl1[r_state] : w_tbl0[r_state]);
            w_enter_match = (w_next == S_MATCH);
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_enter_match),
        .count (match_count)
    );

    assign o       = (r_state == S_MATCH);
    assign state_o = SW'(r_state);

endmodule
